dmem_req: RTL

Data-memory request unit between the execute stage and the memory stage of the orion pipeline. It accepts one load or store per cycle from execute, aligns the address, generates byte masks and replicates store data. It drives the registered request onto the dmem port and holds it stable until `dmem_resp_i`. The memory stage consumes the same `dmem_resp_i` to complete the load or store. This block guarantees that exactly one request is outstanding at a time and that a flush never creates a new memory side effect.

---
 rtl/dmem_req.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_req.sv
// Data-memory request unit: aligns load/store requests from execute and holds them on the dmem port until dmem_resp_i.
// Optional build macro ORION_MISALIGN_TRAP_EN: detect illegal ops, consume them without a request, and pulse misalign_o.
module dmem_req #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ADDRW = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic [2:0]       funct3_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             misalign_o,
    output logic [ADDRW-1:0] dmem_addr_o,
    output logic [3:0]       dmem_rmask_o,
    output logic [3:0]       dmem_wmask_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_resp_i
);

    localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
    localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
    localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
    localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
    localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q;
    logic [ADDRW-1:0] addr_q;
    logic [3:0]       rmask_q;
    logic [3:0]       wmask_q;
    logic [XLEN-1:0]  wdata_q;

    logic             mop;
    logic             acc;
    logic             ready;
    logic [1:0]       off;
    logic [3:0]       mask_d;
    logic [XLEN-1:0]  sdata_d;

    assign off   = addr_i[1:0];
    assign mop   = valid_i & (is_load_i | is_store_i) & ~flush_i;
    assign ready = (state_q == IDLE) | dmem_resp_i;
    assign acc   = mop & ready;

    // Unknown funct3 falls through to a full-word access.
    always_comb begin
        mask_d  = 4'b1111;
        sdata_d = wdata_i;
        case (funct3_i)
            FUNCT3_LS_B, FUNCT3_LS_BU: begin
                mask_d  = 4'b0001 << off;
                sdata_d = XLEN'({4{wdata_i[7:0]}});
            end
            FUNCT3_LS_H, FUNCT3_LS_HU: begin
                mask_d  = 4'b0011 << {off[1], 1'b0};
                sdata_d = XLEN'({2{wdata_i[15:0]}});
            end
            default: begin
                mask_d  = 4'b1111;
                sdata_d = wdata_i;
            end
        endcase
    end

`ifdef ORION_MISALIGN_TRAP_EN
    logic illegal_d;
    logic misalign_q;

    always_comb begin
        illegal_d = 1'b0;
        case (funct3_i)
            FUNCT3_LS_B, FUNCT3_LS_BU: illegal_d = 1'b0;
            FUNCT3_LS_H, FUNCT3_LS_HU: illegal_d = off[0];
            FUNCT3_LS_W:               illegal_d = (off != 2'b00);
            default:                   illegal_d = 1'b1;
        endcase
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
`ifdef ORION_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef ORION_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            if (acc) begin
`ifdef ORION_MISALIGN_TRAP_EN
                if (illegal_d) begin
                    // Consumed as a trap: no request, any finished one retires.
                    state_q    <= IDLE;
                    rmask_q    <= '0;
                    wmask_q    <= '0;
                    misalign_q <= 1'b1;
                end else
`endif
                begin
                    state_q <= BUSY;
                    addr_q  <= {addr_i[ADDRW-1:2], 2'b00};
                    if (is_store_i) begin
                        rmask_q <= '0;
                        wmask_q <= mask_d;
                        wdata_q <= sdata_d;
                    end else begin
                        rmask_q <= mask_d;
                        wmask_q <= '0;
                        wdata_q <= '0;
                    end
                end
            end else if ((state_q == BUSY) && dmem_resp_i) begin
                state_q <= IDLE;
                rmask_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    assign ready_o      = ready;
    assign stall_o      = mop & ~ready;
    assign dmem_addr_o  = addr_q;
    assign dmem_rmask_o = rmask_q;
    assign dmem_wmask_o = wmask_q;
    assign dmem_wdata_o = wdata_q;
`ifdef ORION_MISALIGN_TRAP_EN
    assign misalign_o   = misalign_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule
